// File: rtl/rst_seq_pkg.sv
// Shared types for the Wishbone reset sequencer: FSM states, reset-cause codes
// and a constant helper used to size the shared cycle counter.
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_QUIESCE,
    ST_ASSERT,
    ST_RELEASE,
    ST_REBOOT
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_SOFT = 2'd1,
    CAUSE_BTN  = 2'd2
  } cause_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Board-button conditioner: 2-FF synchroniser, consecutive-press counter and a
// one-shot event that re-arms only after the synchronised button is released.
module rst_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_n_i,
  output logic event_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             armed_q;
  logic             event_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order in the block.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      armed_q <= 1'b1;
      event_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n_i};
      event_q <= 1'b0;
      if (sync_q[1]) begin
        cnt_q   <= '0;
        armed_q <= 1'b1;
      end else if (armed_q) begin
        if (cnt_q == CNT_LAST) begin
          event_q <= 1'b1;
          armed_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign event_o = event_q;

endmodule

// File: rtl/wb_reset_sequencer.sv
// Reset sequencer: turns a soft request or debounced button into a staged
// system/peripheral reset, or a PROGRAMN pulse that reboots the ECP5.
module wb_reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int HOLD_CYCLES     = 16,
  parameter int RELEASE_GAP     = 8,
  parameter int QUIESCE_MAX     = 64,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int PROG_CYCLES     = 4,
  parameter bit REBOOT_ON_SOFT  = 1'b1
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_n_i,
  input  logic       reset_req_i,
  input  logic       btn_n_i,
  input  logic       bus_cyc_i,
  output logic       sys_rst_o,
  output logic       periph_rst_o,
  output logic       programn_o,
  output logic       busy_o,
  output logic [1:0] rst_cause_o
);

  localparam int MAX_CYC = max_int(max_int(max_int(HOLD_CYCLES, RELEASE_GAP),
                                           max_int(QUIESCE_MAX, DEBOUNCE_CYCLES)),
                                   PROG_CYCLES);
  localparam int CNT_W = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_GAP - 1);
  localparam logic [CNT_W-1:0] QUIESCE_LAST = CNT_W'(QUIESCE_MAX - 1);
  localparam logic [CNT_W-1:0] PROG_LAST    = CNT_W'(PROG_CYCLES - 1);

  state_e           state_q;
  cause_e           cause_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req_q;
  logic             sys_rst_q;
  logic             periph_rst_q;
  logic             programn_q;
  logic             busy_q;

  logic   btn_event;
  logic   soft_edge;
  logic   trigger;
  cause_e trig_cause;

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_i   (wb_clk_i),
    .rst_n_i (wb_rst_n_i),
    .btn_n_i (btn_n_i),
    .event_o (btn_event)
  );

  // sys_rst_o re-asserts the request register, so only a rising edge may trigger.
  assign soft_edge  = reset_req_i & ~req_q;
  assign trigger    = soft_edge | btn_event;
  assign trig_cause = btn_event ? CAUSE_BTN : CAUSE_SOFT;

  // NOTE: the async reset lands directly in ASSERT with every output in its
  // reset level, so power-on and mid-sequence resets share one path.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= ST_ASSERT;
      cause_q      <= CAUSE_POR;
      cnt_q        <= '0;
      req_q        <= 1'b1;
      sys_rst_q    <= 1'b1;
      periph_rst_q <= 1'b1;
      programn_q   <= 1'b1;
      busy_q       <= 1'b1;
    end else begin
      req_q <= reset_req_i;
      case (state_q)
        ST_IDLE: begin
          if (trigger) begin
            state_q <= ST_QUIESCE;
            cause_q <= trig_cause;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_QUIESCE: begin
          if (!bus_cyc_i || cnt_q == QUIESCE_LAST) begin
            state_q      <= ST_ASSERT;
            cnt_q        <= '0;
            sys_rst_q    <= 1'b1;
            periph_rst_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_ASSERT: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_q <= '0;
            if (cause_q == CAUSE_SOFT && REBOOT_ON_SOFT) begin
              state_q    <= ST_REBOOT;
              programn_q <= 1'b0;
            end else begin
              state_q   <= ST_RELEASE;
              sys_rst_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == RELEASE_LAST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            periph_rst_q <= 1'b0;
            busy_q       <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_REBOOT: begin
          // The counter only runs during the pulse; afterwards wait for reconfiguration.
          if (!programn_q) begin
            if (cnt_q == PROG_LAST) begin
              programn_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_ASSERT;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign sys_rst_o    = sys_rst_q;
  assign periph_rst_o = periph_rst_q;
  assign programn_o   = programn_q;
  assign busy_o       = busy_q;
  assign rst_cause_o  = cause_q;

endmodule

// File: tb/tb_wb_reset_sequencer.sv
// Directed bench for wb_reset_sequencer: one instance rebooting on soft
// requests (u_r) and one that only resets logic (u_n), sharing all inputs.
module tb_wb_reset_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic req   = 1'b0;
  logic btn_n = 1'b1;
  logic cyc   = 1'b0;

  logic       sys_r, per_r, prog_r, busy_r;
  logic [1:0] cause_r;
  logic       sys_n, per_n, prog_n, busy_n;
  logic [1:0] cause_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_reset_sequencer #(.DEBOUNCE_CYCLES(8), .REBOOT_ON_SOFT(1'b1)) u_r (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .reset_req_i(req), .btn_n_i(btn_n),
    .bus_cyc_i(cyc), .sys_rst_o(sys_r), .periph_rst_o(per_r),
    .programn_o(prog_r), .busy_o(busy_r), .rst_cause_o(cause_r)
  );

  wb_reset_sequencer #(.DEBOUNCE_CYCLES(8), .REBOOT_ON_SOFT(1'b0)) u_n (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .reset_req_i(req), .btn_n_i(btn_n),
    .bus_cyc_i(cyc), .sys_rst_o(sys_n), .periph_rst_o(per_n),
    .programn_o(prog_n), .busy_o(busy_n), .rst_cause_o(cause_n)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Releases reset and records, in clock edges after release, when u_r drops its resets.
  task automatic watch_por(output int sys0, output int per0, output int busy0, output int prog_lo);
    sys0 = -1; per0 = -1; busy0 = -1; prog_lo = 0;
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (!sys_r && sys0 < 0) sys0 = k;
      if (!per_r && per0 < 0) per0 = k;
      if (!busy_r && busy0 < 0) busy0 = k;
      if (!prog_r) prog_lo++;
    end
  endtask

  task automatic por_to_idle();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (24) tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sys_r, per_r, prog_r, busy_r, cause_r} !== 6'b1111_00) begin
      errors++;
      $display("FAIL reset_r: {sys,per,prog,busy,cause}=%b expected 111100", {sys_r, per_r, prog_r, busy_r, cause_r});
    end
    checks++;
    if ({sys_n, per_n, prog_n, busy_n, cause_n} !== 6'b1111_00) begin
      errors++;
      $display("FAIL reset_n: {sys,per,prog,busy,cause}=%b expected 111100", {sys_n, per_n, prog_n, busy_n, cause_n});
    end
    repeat (3) tick();
  endtask

  task automatic test_por();
    int s0, p0, b0, pl;
    watch_por(s0, p0, b0, pl);
    checks++;
    if (s0 !== 16) begin errors++; $display("FAIL por_sys_drop: edge %0d expected 16", s0); end
    checks++;
    if (p0 !== 24) begin errors++; $display("FAIL por_periph_drop: edge %0d expected 24", p0); end
    checks++;
    if (b0 !== 24) begin errors++; $display("FAIL por_busy_drop: edge %0d expected 24", b0); end
    checks++;
    if (pl !== 0 || cause_r !== 2'd0) begin
      errors++; $display("FAIL por_cause_prog: prog_low=%0d cause=%0d expected 0 0", pl, cause_r);
    end
  endtask

  task automatic test_soft_reboot();
    int first_sys = -1, first_prog = -1, prog_cnt = 0, prog_n_lo = 0;
    cyc = 1'b0;
    req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (sys_r && first_sys < 0) first_sys = k;
      if (!prog_r) begin
        if (first_prog < 0) first_prog = k;
        prog_cnt++;
      end
      if (!prog_n) prog_n_lo++;
    end
    checks++;
    if (first_sys !== 2) begin errors++; $display("FAIL soft_assert_start: edge %0d expected 2", first_sys); end
    checks++;
    if (first_prog !== 18) begin errors++; $display("FAIL soft_prog_start: edge %0d expected 18", first_prog); end
    checks++;
    if (prog_cnt !== 4) begin errors++; $display("FAIL soft_prog_width: %0d cycles expected 4", prog_cnt); end
    checks++;
    if ({sys_r, per_r, prog_r, busy_r, cause_r} !== 6'b1111_01) begin
      errors++;
      $display("FAIL soft_reboot_hold: {sys,per,prog,busy,cause}=%b expected 111101", {sys_r, per_r, prog_r, busy_r, cause_r});
    end
    checks++;
    if (prog_n_lo !== 0 || busy_n !== 1'b0 || cause_n !== 2'd1) begin
      errors++;
      $display("FAIL soft_noreboot: prog_low=%0d busy=%b cause=%0d expected 0 0 1", prog_n_lo, busy_n, cause_n);
    end
  endtask

  task automatic test_soft_quiesce();
    int first_sys = -1, first_idle = -1, prog_n_lo = 0, first_prog = -1;
    req = 1'b0;
    por_to_idle();
    cyc = 1'b1;
    req = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      tick();
      if (sys_n && first_sys < 0) first_sys = k;
      if (!busy_n && first_sys > 0 && first_idle < 0) first_idle = k;
      if (!prog_n) prog_n_lo++;
      if (!prog_r && first_prog < 0) first_prog = k;
    end
    cyc = 1'b0;
    checks++;
    if (first_sys !== 65) begin errors++; $display("FAIL quiesce_timeout: assert at edge %0d expected 65", first_sys); end
    checks++;
    if (first_idle !== 89) begin errors++; $display("FAIL quiesce_idle: idle at edge %0d expected 89", first_idle); end
    checks++;
    if (prog_n_lo !== 0 || cause_n !== 2'd1) begin
      errors++; $display("FAIL quiesce_cause: prog_low=%0d cause=%0d expected 0 1", prog_n_lo, cause_n);
    end
    checks++;
    if (first_prog !== 81) begin errors++; $display("FAIL quiesce_reboot: prog low at edge %0d expected 81", first_prog); end
  endtask

  task automatic test_button();
    int busy_seen = 0, rises = 0, first_rise = -1, prog_lo = 0;
    logic prev;
    req = 1'b0;
    por_to_idle();
    btn_n = 1'b0;
    repeat (5) tick();
    btn_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (busy_n) busy_seen++;
    end
    checks++;
    if (busy_seen !== 0) begin errors++; $display("FAIL btn_glitch: busy for %0d cycles expected 0", busy_seen); end

    prev  = busy_n;
    btn_n = 1'b0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      if (k == 20) btn_n = 1'b1;
      if (busy_n && !prev) begin
        rises++;
        if (first_rise < 0) first_rise = k;
      end
      prev = busy_n;
    end
    checks++;
    if (rises !== 1 || first_rise !== 11) begin
      errors++; $display("FAIL btn_press: rises=%0d first=%0d expected 1 11", rises, first_rise);
    end
    checks++;
    if (cause_n !== 2'd2 || busy_n !== 1'b0) begin
      errors++; $display("FAIL btn_cause: cause=%0d busy=%b expected 2 0", cause_n, busy_n);
    end

    rises = 0;
    prev  = busy_r;
    btn_n = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 70) btn_n = 1'b1;
      if (busy_r && !prev) rises++;
      if (!prog_r) prog_lo++;
      prev = busy_r;
    end
    checks++;
    if (rises !== 1 || prog_lo !== 0 || cause_r !== 2'd2) begin
      errors++; $display("FAIL btn_long_hold: rises=%0d prog_low=%0d cause=%0d expected 1 0 2", rises, prog_lo, cause_r);
    end
  endtask

  task automatic test_sticky();
    int rises = 0;
    logic prev;
    prev = busy_n;
    req  = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (busy_n && !prev) rises++;
      prev = busy_n;
    end
    checks++;
    if (rises !== 1 || busy_n !== 1'b0) begin
      errors++; $display("FAIL sticky_req: sequences=%0d busy=%b expected 1 0", rises, busy_n);
    end
  endtask

  task automatic test_both();
    int first_busy = -1, prog_lo = 0;
    req = 1'b0;
    por_to_idle();
    btn_n = 1'b0;
    repeat (10) tick();
    req = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (k == 5) btn_n = 1'b1;
      if (busy_r && first_busy < 0) first_busy = k;
      if (!prog_r) prog_lo++;
    end
    checks++;
    if (first_busy !== 1 || cause_r !== 2'd2) begin
      errors++; $display("FAIL both_cause: start=%0d cause=%0d expected 1 2", first_busy, cause_r);
    end
    checks++;
    if (prog_lo !== 0 || busy_r !== 1'b0) begin
      errors++; $display("FAIL both_noreboot: prog_low=%0d busy=%b expected 0 0", prog_lo, busy_r);
    end
  endtask

  task automatic test_async_mid_release();
    int s0, p0, b0, pl;
    req = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    checks++;
    if (sys_r !== 1'b0 || per_r !== 1'b1) begin
      errors++; $display("FAIL mid_release_state: sys=%b per=%b expected 0 1", sys_r, per_r);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sys_r, per_r, prog_r, busy_r} !== 4'b1111) begin
      errors++; $display("FAIL mid_release_async: {sys,per,prog,busy}=%b expected 1111", {sys_r, per_r, prog_r, busy_r});
    end
    repeat (3) tick();
    watch_por(s0, p0, b0, pl);
    checks++;
    if (s0 !== 16 || b0 !== 24) begin
      errors++; $display("FAIL mid_release_por: sys_drop=%0d busy_drop=%0d expected 16 24", s0, b0);
    end
  endtask

  task automatic test_async_mid_reboot();
    int s0, p0, b0, pl;
    req = 1'b1;
    repeat (19) tick();
    checks++;
    if (prog_r !== 1'b0) begin errors++; $display("FAIL mid_reboot_state: prog=%b expected 0", prog_r); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({sys_r, per_r, prog_r, busy_r, cause_r} !== 6'b1111_00) begin
      errors++;
      $display("FAIL mid_reboot_async: {sys,per,prog,busy,cause}=%b expected 111100", {sys_r, per_r, prog_r, busy_r, cause_r});
    end
    req = 1'b0;
    repeat (3) tick();
    watch_por(s0, p0, b0, pl);
    checks++;
    if (s0 !== 16 || p0 !== 24 || pl !== 0) begin
      errors++; $display("FAIL mid_reboot_por: sys_drop=%0d per_drop=%0d prog_low=%0d expected 16 24 0", s0, p0, pl);
    end
  endtask

  initial begin
    test_reset();
    test_por();
    test_soft_reboot();
    test_soft_quiesce();
    test_button();
    test_sticky();
    test_both();
    test_async_mid_release();
    test_async_mid_reboot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
